pkt_attr_extract: RTL and testbench

Passive AXI4-Stream tap that parses Ethernet/VLAN/IPv4/TCP/UDP headers of every packet crossing the monitoring datapath. For each packet it emits one attribute word: source port, protocol flags, byte count and 5-tuple. The block sits directly upstream of the statistics handler and drives its `pkt_attributes`/`pkt_valid` inputs. It never asserts backpressure.

---
 rtl/pkt_attr_extract.sv | 192 +++++++++++++++++++
 tb/tb_pkt_attr_extract.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_attr_extract.sv
// pkt_attr_extract
//   Passive AXI4-Stream tap. Captures the first three beats (96 bytes) of
//   every packet, decodes Ethernet / 802.1Q / 802.1ad / IPv4 / TCP / UDP
//   headers on the tlast beat and emits one registered attribute word
//   qualified by a one-cycle strobe. Never drives backpressure.
//
// Ports
//   axi_aclk        clock
//   axi_resetn      async active-low reset (released synchronously inside)
//   s_axis_tdata    frame bytes, byte n at [8n+7:8n]
//   s_axis_tuser    [15:0] packet length, [23:16] one-hot source port
//   s_axis_tvalid   observed
//   s_axis_tready   observed; a beat transfers on tvalid & tready
//   s_axis_tlast    last beat of packet
//   pkt_attributes  {src_port, 2'b0, vlan_ad, vlan_q, udp, tcp, ip, len, tuple}
//   pkt_valid       one-cycle strobe, cycle after the tlast transfer
module pkt_attr_extract #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_INPUT_QUEUES     = 8,
    parameter int TUPLE_WIDTH          = 104,
    parameter int BYTES_COUNT_WIDTH    = 16,
    parameter int ATTRIBUTE_DATA_WIDTH = 135
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [ATTRIBUTE_DATA_WIDTH-1:0] pkt_attributes,
    output logic                            pkt_valid
);

    localparam int W     = C_S_AXIS_DATA_WIDTH;
    localparam int HDR_W = 3 * W;

    localparam logic [0:0] S_HDR  = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    // ------------------------------------------------------------------
    // Reset: asserts immediately, releases two clocks after axi_resetn.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // ------------------------------------------------------------------
    // Capture state
    // ------------------------------------------------------------------
    logic [0:0]       state;
    logic [1:0]       cnt;
    logic [HDR_W-1:0] hdr_buf;
    logic [23:0]      tuser_q;

    logic             xfer;
    logic             sop;
    logic [HDR_W-1:0] hdr;
    logic [23:0]      tuser_pkt;
    logic             unused_tuser_hi;

    assign xfer      = s_axis_tvalid && s_axis_tready;
    assign sop       = (state == S_HDR) && (cnt == 2'd0);
    assign tuser_pkt = sop ? s_axis_tuser[23:0] : tuser_q;
    assign unused_tuser_hi = ^s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:24];

    // Header view = stored beats merged with the current beat. On SOP the
    // upper beats are forced to zero so a short packet reads 0 past tlast.
    always_comb begin
        hdr = hdr_buf;
        if (state == S_HDR) begin
            case (cnt)
                2'd0:    hdr = {{(2*W){1'b0}}, s_axis_tdata};
                2'd1:    hdr[2*W-1:W] = s_axis_tdata;
                default: hdr[3*W-1:2*W] = s_axis_tdata;
            endcase
        end
    end

    function automatic logic [7:0] hbyte(input logic [HDR_W-1:0] v,
                                         input logic [6:0]       idx);
        return v[{idx, 3'b000} +: 8];
    endfunction

    // ------------------------------------------------------------------
    // Header decode (combinational, consumed on the tlast transfer)
    // ------------------------------------------------------------------
    logic                         vlan_ad, vlan_q, ip, tcp, udp;
    logic [15:0]                  ether_type;
    logic [6:0]                   l3_off, l4_off;
    logic [7:0]                   ver_ihl, proto;
    logic [31:0]                  src_ip, dst_ip;
    logic [15:0]                  src_l4, dst_l4;
    logic [TUPLE_WIDTH-1:0]       tuple;
    logic [NUM_INPUT_QUEUES-1:0]  src_port;
    logic [BYTES_COUNT_WIDTH-1:0] pkt_len;
    logic [ATTRIBUTE_DATA_WIDTH-1:0] attr;

    always_comb begin
        vlan_ad    = 1'b0;
        vlan_q     = 1'b0;
        ether_type = {hbyte(hdr, 7'd12), hbyte(hdr, 7'd13)};
        l3_off     = 7'd14;
        if (ether_type == 16'h88A8) begin
            // Inner tag is assumed, not checked.
            vlan_ad    = 1'b1;
            ether_type = {hbyte(hdr, 7'd20), hbyte(hdr, 7'd21)};
            l3_off     = 7'd22;
        end else if (ether_type == 16'h8100) begin
            vlan_q     = 1'b1;
            ether_type = {hbyte(hdr, 7'd16), hbyte(hdr, 7'd17)};
            l3_off     = 7'd18;
        end

        ver_ihl = hbyte(hdr, l3_off);
        ip      = (ether_type == 16'h0800) && (ver_ihl[7:4] == 4'd4);
        l4_off  = l3_off + {1'b0, ver_ihl[3:0], 2'b00};

        proto  = '0;
        src_ip = '0;
        dst_ip = '0;
        if (ip) begin
            proto  = hbyte(hdr, l3_off + 7'd9);
            src_ip = {hbyte(hdr, l3_off + 7'd12), hbyte(hdr, l3_off + 7'd13),
                      hbyte(hdr, l3_off + 7'd14), hbyte(hdr, l3_off + 7'd15)};
            dst_ip = {hbyte(hdr, l3_off + 7'd16), hbyte(hdr, l3_off + 7'd17),
                      hbyte(hdr, l3_off + 7'd18), hbyte(hdr, l3_off + 7'd19)};
        end

        tcp = ip && (proto == 8'd6);
        udp = ip && (proto == 8'd17);

        src_l4 = '0;
        dst_l4 = '0;
        if (tcp || udp) begin
            src_l4 = {hbyte(hdr, l4_off),         hbyte(hdr, l4_off + 7'd1)};
            dst_l4 = {hbyte(hdr, l4_off + 7'd2),  hbyte(hdr, l4_off + 7'd3)};
        end

        tuple    = {src_ip, dst_ip, src_l4, dst_l4, proto};
        src_port = tuser_pkt[23:16];
        pkt_len  = tuser_pkt[15:0];
        attr     = {src_port, 2'b00, vlan_ad, vlan_q, udp, tcp, ip, pkt_len, tuple};
    end

    // ------------------------------------------------------------------
    // Sequential state and registered output
    // ------------------------------------------------------------------
    always_ff @(posedge axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_HDR;
            cnt            <= '0;
            hdr_buf        <= '0;
            tuser_q        <= '0;
            pkt_valid      <= 1'b0;
            pkt_attributes <= '0;
        end else begin
            pkt_valid <= 1'b0;
            if (xfer) begin
                if (sop) begin
                    tuser_q <= s_axis_tuser[23:0];
                end
                if (state == S_HDR) begin
                    hdr_buf <= hdr;
                end
                if (s_axis_tlast) begin
                    state          <= S_HDR;
                    cnt            <= '0;
                    pkt_valid      <= 1'b1;
                    pkt_attributes <= attr;
                end else if (state == S_HDR) begin
                    if (cnt == 2'd2) begin
                        state <= S_BODY;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_attr_extract.sv
module tb_pkt_attr_extract;

    logic         clk = 1'b0;
    logic         axi_resetn;
    logic [255:0] s_axis_tdata;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [134:0] pkt_attributes;
    logic         pkt_valid;

    always #5 clk = ~clk;

    pkt_attr_extract #(
        .C_S_AXIS_DATA_WIDTH (256),
        .C_S_AXIS_TUSER_WIDTH(128),
        .NUM_INPUT_QUEUES    (8),
        .TUPLE_WIDTH         (104),
        .BYTES_COUNT_WIDTH   (16),
        .ATTRIBUTE_DATA_WIDTH(135)
    ) dut (
        .axi_aclk      (clk),
        .axi_resetn    (axi_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .pkt_attributes(pkt_attributes),
        .pkt_valid     (pkt_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt = 0;
    bit mon_en   = 0;
    bit in_reset = 1;

    logic [7:0]   pkt [256];
    logic [134:0] exp_q [$];

    typedef struct {
        int           vm;
        logic [15:0]  et;
        logic [7:0]   vi;
        logic [7:0]   pr;
        logic [31:0]  s;
        logic [31:0]  d;
        logic [15:0]  sp;
        logic [15:0]  dp;
        int           nb;
        logic [127:0] tu;
        logic [134:0] ex;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [134:0] act, input logic [134:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic vec_t mk(input int vm, input logic [15:0] et, input logic [7:0] vi,
                                input logic [7:0] pr, input logic [31:0] s, input logic [31:0] d,
                                input logic [15:0] sp, input logic [15:0] dp, input int nb,
                                input logic [127:0] tu, input logic [134:0] ex);
        vec_t v;
        v.vm = vm; v.et = et; v.vi = vi; v.pr = pr; v.s = s; v.d = d;
        v.sp = sp; v.dp = dp; v.nb = nb; v.tu = tu; v.ex = ex;
        return v;
    endfunction

    // Builds a frame into pkt[]: random filler, then tags and IPv4/L4 fields.
    task automatic build(input int vm, input logic [15:0] et, input logic [7:0] vi,
                         input logic [7:0] pr, input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] sp, input logic [15:0] dp);
        int l3, l4;
        for (int i = 0; i < 256; i++) pkt[i] = 8'($urandom);
        if (vm == 2) begin
            pkt[12] = 8'h88; pkt[13] = 8'hA8; pkt[16] = 8'h81; pkt[17] = 8'h00;
            pkt[20] = et[15:8]; pkt[21] = et[7:0]; l3 = 22;
        end else if (vm == 1) begin
            pkt[12] = 8'h81; pkt[13] = 8'h00; pkt[16] = et[15:8]; pkt[17] = et[7:0]; l3 = 18;
        end else begin
            pkt[12] = et[15:8]; pkt[13] = et[7:0]; l3 = 14;
        end
        l4 = l3 + 4 * int'(vi[3:0]);
        pkt[l4] = sp[15:8]; pkt[l4+1] = sp[7:0]; pkt[l4+2] = dp[15:8]; pkt[l4+3] = dp[7:0];
        pkt[l3] = vi; pkt[l3+9] = pr;
        for (int i = 0; i < 4; i++) begin
            pkt[l3+12+i] = s[31-8*i -: 8];
            pkt[l3+16+i] = d[31-8*i -: 8];
        end
    endtask

    function automatic int gb(input int i, input int hb);
        if (i < hb) return int'(pkt[i]);
        return 0;
    endfunction

    // Reference: parse the byte image of the first (up to) three beats.
    function automatic logic [134:0] model(input logic [127:0] tu, input int nb);
        int hb, e, l3, vi, l4, pr;
        bit vad, vq, ip, tcp, udp;
        logic [31:0] s, d;
        logic [15:0] sp, dp;
        hb = ((nb < 3) ? nb : 3) * 32;
        vad = 0; vq = 0; l3 = 14;
        e = gb(12, hb) * 256 + gb(13, hb);
        if (e == 'h88A8) begin
            vad = 1; e = gb(20, hb) * 256 + gb(21, hb); l3 = 22;
        end else if (e == 'h8100) begin
            vq = 1; e = gb(16, hb) * 256 + gb(17, hb); l3 = 18;
        end
        vi = gb(l3, hb);
        ip = (e == 'h0800) && (vi / 16 == 4);
        pr = ip ? gb(l3 + 9, hb) : 0;
        s = '0; d = '0;
        if (ip) begin
            for (int i = 0; i < 4; i++) begin
                s[31-8*i -: 8] = 8'(gb(l3 + 12 + i, hb));
                d[31-8*i -: 8] = 8'(gb(l3 + 16 + i, hb));
            end
        end
        tcp = ip && (pr == 6);
        udp = ip && (pr == 17);
        l4 = l3 + 4 * (vi % 16);
        sp = '0; dp = '0;
        if (tcp || udp) begin
            sp = 16'(gb(l4, hb) * 256 + gb(l4 + 1, hb));
            dp = 16'(gb(l4 + 2, hb) * 256 + gb(l4 + 3, hb));
        end
        return {tu[23:16], 2'b00, vad, vq, udp, tcp, ip, tu[15:0], s, d, sp, dp, 8'(pr)};
    endfunction

    task automatic drive(input logic v, input logic r, input logic l,
                         input logic [255:0] dd, input logic [127:0] u);
        s_axis_tvalid = v; s_axis_tready = r; s_axis_tlast = l;
        s_axis_tdata = dd; s_axis_tuser = u;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'($urandom), rnd256(), {rnd256()}[127:0]);
    endtask

    function automatic logic [255:0] beat(input int b);
        logic [255:0] dd;
        for (int n = 0; n < 32; n++) dd[8*n +: 8] = pkt[b*32 + n];
        return dd;
    endfunction

    // Sends pkt[] as nb beats; tuser is meaningful on beat 0 only.
    task automatic send(input int nb, input logic [127:0] tu, input int stall_pct,
                        input logic [134:0] ex);
        logic [255:0] dd;
        int ns;
        for (int b = 0; b < nb; b++) begin
            dd = beat(b);
            ns = 0;
            while (stall_pct > 0 && ns < 4 && $urandom_range(99) < stall_pct) begin
                if ($urandom_range(1) == 1) drive(1'b0, 1'b1, 1'b0, rnd256(), tu);
                else                        drive(1'b1, 1'b0, 1'(b == nb - 1), dd, tu);
                ns++;
            end
            if (b == nb - 1) exp_q.push_back(ex);
            drive(1'b1, 1'b1, 1'(b == nb - 1), dd, (b == 0) ? tu : {rnd256()}[127:0]);
        end
    endtask

    // Strobe monitor: pkt_valid must follow every tlast transfer by one cycle.
    initial begin : monitor
        bit xl;
        logic [134:0] ex;
        forever begin
            @(posedge clk);
            xl = s_axis_tvalid && s_axis_tready && s_axis_tlast && !in_reset;
            @(negedge clk);
            if (mon_en) begin
                if (pkt_valid) strobe_cnt++;
                chk("strobe_timing", 135'(pkt_valid), 135'(xl));
                if (xl) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 135'(1), 135'(0));
                    end else begin
                        ex = exp_q.pop_front();
                        if (pkt_valid) chk("attributes", pkt_attributes, ex);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s0, vm, nb;
        logic [15:0] et;
        logic [7:0]  vi, pr;
        logic [127:0] tu;

        vecs[0] = mk(0, 16'h0800, 8'h45, 8'h06, 32'h0A000001, 32'h0A000002, 16'd80, 16'd443,
                     2, 128'h0001_0040,
                     {8'h01, 2'b00, 5'b00011, 16'h0040, 32'h0A000001, 32'h0A000002, 16'h0050, 16'h01BB, 8'h06});
        vecs[1] = mk(2, 16'h0800, 8'h4F, 8'h11, 32'hC0A80101, 32'hC0A80102, 16'd53, 16'd1000,
                     4, 128'h0040_0080,
                     {8'h40, 2'b00, 5'b10101, 16'h0080, 32'hC0A80101, 32'hC0A80102, 16'h0035, 16'h03E8, 8'h11});
        vecs[2] = mk(0, 16'h0806, 8'h45, 8'h06, 32'h01020304, 32'h05060708, 16'h1111, 16'h2222,
                     2, 128'h0002_003C,
                     {8'h02, 2'b00, 5'b00000, 16'h003C, 104'h0});
        vecs[3] = mk(1, 16'h0800, 8'h45, 8'h11, 32'h0A010203, 32'hC0A80001, 16'h1234, 16'h5678,
                     1, 128'h0004_0020,
                     {8'h04, 2'b00, 5'b01101, 16'h0020, 32'h0A010000, 32'h0, 16'h0, 16'h0, 8'h11});

        // Reset
        axi_resetn = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tready = 1'b1; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; s_axis_tuser = '0;
        #2 axi_resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 135'(pkt_valid), 135'(0));
        chk("reset_attributes", pkt_attributes, 135'(0));
        axi_resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_reset = 0;
        mon_en   = 1;

        // Directed table
        for (int i = 0; i < 4; i++) begin
            build(vecs[i].vm, vecs[i].et, vecs[i].vi, vecs[i].pr, vecs[i].s, vecs[i].d,
                  vecs[i].sp, vecs[i].dp);
            send(vecs[i].nb, vecs[i].tu, 0, vecs[i].ex);
            idle(2);
        end

        // Stalled 3-beat packet then four back-to-back single-beat packets
        s0 = strobe_cnt;
        build(0, 16'h0800, 8'h45, 8'h06, 32'h0A000001, 32'h0A000002, 16'd80, 16'd443);
        tu = 128'h0010_00A0;
        send(3, tu, 60, model(tu, 3));
        for (int k = 0; k < 4; k++) begin
            build(int'($urandom_range(2)), 16'h0800, 8'h45, 8'h11, $urandom, $urandom,
                  16'($urandom), 16'($urandom));
            tu = {104'h0, 8'(1 << k), 16'd32};
            send(1, tu, 0, model(tu, 1));
        end
        idle(3);
        chk("b2b_strobe_count", 135'(strobe_cnt - s0), 135'(5));

        // Reset during beat 1 of a 3-beat packet
        build(0, 16'h0800, 8'h45, 8'h06, 32'h0A000001, 32'h0A000002, 16'd80, 16'd443);
        drive(1'b1, 1'b1, 1'b0, beat(0), 128'h0001_0040);
        s_axis_tdata = beat(1); s_axis_tuser = '0;
        s_axis_tvalid = 1'b1; s_axis_tready = 1'b1; s_axis_tlast = 1'b0;
        #2;
        in_reset = 1;
        axi_resetn = 1'b0;
        #1;
        chk("midreset_valid", 135'(pkt_valid), 135'(0));
        chk("midreset_attributes", pkt_attributes, 135'(0));
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b1, beat(2), '0);
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        axi_resetn = 1'b1;
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        idle(3);
        in_reset = 0;
        send(vecs[0].nb, vecs[0].tu, 0, vecs[0].ex);
        idle(2);

        // Randomized packets against the reference model
        for (int k = 0; k < 40; k++) begin
            vm = int'($urandom_range(2));
            case ($urandom_range(3))
                0, 1:    et = 16'h0800;
                2:       et = 16'h0806;
                default: et = 16'($urandom);
            endcase
            vi = ($urandom_range(3) != 0) ? {4'h4, 4'($urandom)} : 8'($urandom);
            case ($urandom_range(3))
                0:       pr = 8'd6;
                1:       pr = 8'd17;
                2:       pr = 8'd1;
                default: pr = 8'($urandom);
            endcase
            nb = int'($urandom_range(1, 5));
            tu = {rnd256()}[127:0];
            build(vm, et, vi, pr, $urandom, $urandom, 16'($urandom), 16'($urandom));
            send(nb, tu, 30, model(tu, nb));
            if ($urandom_range(1) == 1) idle(int'($urandom_range(2)));
        end
        idle(3);
        chk("scoreboard_drained", 135'(exp_q.size()), 135'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
